// File: rtl/rv_pkg.sv
// Shared datapath widths, ALU select encodings and the ID/EX register layout.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = $clog2(NREG);

    // Shared ALU select encodings, as seen on the ALU's AluSel_i input.
    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSll  = 4'd2,
        AluSlt  = 4'd3,
        AluSltu = 4'd4,
        AluXor  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluOr   = 4'd8,
        AluAnd  = 4'd9,
        AluB    = 4'd10
    } alu_sel_e;

    // Everything the execute stage needs, registered together.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] opb;
        logic [XLEN-1:0] store_data;
        logic [3:0]      alu_sel;
        logic [AW-1:0]   rd_addr;
        logic            rd_wen;
        logic            mem_read;
    } id_ex_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one write port, x0 reads 0.
module reg_file
    import rv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            wen_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [NREG];

    // Storage update; x0 is never written so it stays at its reset value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wen_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rs1_data_o = (rs1_addr_i == '0) ? '0 : regs_q[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];

endmodule

// File: rtl/id_ex_operand_stage.sv
// Operand fetch with EX/MEM/WB forwarding, load-use stall, and the ID/EX pipeline register.
module id_ex_operand_stage
    import rv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    input  logic [AW-1:0]   rd_addr_i,
    input  logic            rd_wen_i,
    input  logic            mem_read_i,
    input  logic [3:0]      alu_sel_i,
    input  logic            bsel_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic            mem_fwd_wen_i,
    input  logic [AW-1:0]   mem_fwd_addr_i,
    input  logic [XLEN-1:0] mem_fwd_data_i,
    input  logic            wb_wen_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            stall_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_rs1_o,
    output logic [XLEN-1:0] ex_opb_o,
    output logic [XLEN-1:0] ex_store_data_o,
    output logic [3:0]      ex_alu_sel_o,
    output logic [AW-1:0]   ex_rd_addr_o,
    output logic            ex_rd_wen_o,
    output logic            ex_mem_read_o
);

    id_ex_t          id_ex_q, id_ex_d;
    logic [XLEN-1:0] rf_rs1, rf_rs2;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    logic            ex_can_fwd;

    reg_file u_reg_file (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rs1_addr_i (rs1_addr_i),
        .rs2_addr_i (rs2_addr_i),
        .rs1_data_o (rf_rs1),
        .rs2_data_o (rf_rs2),
        .wen_i      (wb_wen_i),
        .waddr_i    (wb_addr_i),
        .wdata_i    (wb_data_i)
    );

    // A load in EX has no data yet, so it can only be covered by stalling.
    assign ex_can_fwd = id_ex_q.valid && id_ex_q.rd_wen && !id_ex_q.mem_read;

    function automatic logic [XLEN-1:0] pick_operand(input logic [AW-1:0]   addr,
                                                     input logic [XLEN-1:0] rf_data);
        logic [XLEN-1:0] val;
        if (addr == '0) begin
            val = '0;
        end else if (ex_can_fwd && (id_ex_q.rd_addr == addr)) begin
            val = ex_result_i;
        end else if (mem_fwd_wen_i && (mem_fwd_addr_i == addr)) begin
            val = mem_fwd_data_i;
        end else if (wb_wen_i && (wb_addr_i == addr)) begin
            val = wb_data_i;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    // Forwarding muxes, youngest producer first.
    always_comb begin
        fwd_rs1 = pick_operand(rs1_addr_i, rf_rs1);
        fwd_rs2 = pick_operand(rs2_addr_i, rf_rs2);
    end

    // Load-use hazard; rs2 is compared even for immediate forms.
    assign stall_o = valid_i && !flush_i && id_ex_q.valid && id_ex_q.mem_read
                     && (id_ex_q.rd_addr != '0)
                     && ((id_ex_q.rd_addr == rs1_addr_i) || (id_ex_q.rd_addr == rs2_addr_i));

    // Next ID/EX contents: bubble on flush or stall, otherwise the decoded instruction.
    always_comb begin
        id_ex_d = '0;
        if (!flush_i && !stall_o) begin
            id_ex_d.valid      = valid_i;
            id_ex_d.rs1        = fwd_rs1;
            id_ex_d.opb        = bsel_i ? imm_i : fwd_rs2;
            id_ex_d.store_data = fwd_rs2;
            id_ex_d.alu_sel    = alu_sel_i;
            id_ex_d.rd_addr    = rd_addr_i;
            id_ex_d.rd_wen     = valid_i && rd_wen_i;
            id_ex_d.mem_read   = valid_i && mem_read_i;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign ex_valid_o      = id_ex_q.valid;
    assign ex_rs1_o        = id_ex_q.rs1;
    assign ex_opb_o        = id_ex_q.opb;
    assign ex_store_data_o = id_ex_q.store_data;
    assign ex_alu_sel_o    = id_ex_q.alu_sel;
    assign ex_rd_addr_o    = id_ex_q.rd_addr;
    assign ex_rd_wen_o     = id_ex_q.rd_wen;
    assign ex_mem_read_o   = id_ex_q.mem_read;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed and randomized checks of id_ex_operand_stage against a behavioural model.
module tb_id_ex_operand_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, rd_wen_i, mem_read_i, bsel_i, flush_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [3:0]  alu_sel_i;
    logic [31:0] imm_i, ex_result_i;
    logic        mem_fwd_wen_i, wb_wen_i;
    logic [4:0]  mem_fwd_addr_i, wb_addr_i;
    logic [31:0] mem_fwd_data_i, wb_data_i;
    logic        stall_o, ex_valid_o, ex_rd_wen_o, ex_mem_read_o;
    logic [31:0] ex_rs1_o, ex_opb_o, ex_store_data_o;
    logic [3:0]  ex_alu_sel_o;
    logic [4:0]  ex_rd_addr_o;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Model: architectural registers plus the instruction the model believes is in EX.
    logic [31:0] m_rf [32];
    logic        m_valid, m_wen, m_mr;
    logic [4:0]  m_rd;
    logic [31:0] m_rs1, m_opb, m_sd;
    logic [3:0]  m_alu;

    id_ex_operand_stage dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .valid_i         (valid_i),
        .rs1_addr_i      (rs1_addr_i),
        .rs2_addr_i      (rs2_addr_i),
        .rd_addr_i       (rd_addr_i),
        .rd_wen_i        (rd_wen_i),
        .mem_read_i      (mem_read_i),
        .alu_sel_i       (alu_sel_i),
        .bsel_i          (bsel_i),
        .imm_i           (imm_i),
        .flush_i         (flush_i),
        .ex_result_i     (ex_result_i),
        .mem_fwd_wen_i   (mem_fwd_wen_i),
        .mem_fwd_addr_i  (mem_fwd_addr_i),
        .mem_fwd_data_i  (mem_fwd_data_i),
        .wb_wen_i        (wb_wen_i),
        .wb_addr_i       (wb_addr_i),
        .wb_data_i       (wb_data_i),
        .stall_o         (stall_o),
        .ex_valid_o      (ex_valid_o),
        .ex_rs1_o        (ex_rs1_o),
        .ex_opb_o        (ex_opb_o),
        .ex_store_data_o (ex_store_data_o),
        .ex_alu_sel_o    (ex_alu_sel_o),
        .ex_rd_addr_o    (ex_rd_addr_o),
        .ex_rd_wen_o     (ex_rd_wen_o),
        .ex_mem_read_o   (ex_mem_read_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_valid = 0; m_wen = 0; m_mr = 0; m_rd = '0;
        m_rs1 = '0; m_opb = '0; m_sd = '0; m_alu = '0;
    endtask

    task automatic idle_inputs();
        valid_i = 0; rd_wen_i = 0; mem_read_i = 0; bsel_i = 0; flush_i = 0;
        rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0; alu_sel_i = '0; imm_i = '0;
        ex_result_i = '0; mem_fwd_wen_i = 0; mem_fwd_addr_i = '0; mem_fwd_data_i = '0;
        wb_wen_i = 0; wb_addr_i = '0; wb_data_i = '0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wen, input logic ld);
        valid_i = 1; rs1_addr_i = rs1; rs2_addr_i = rs2; rd_addr_i = rd;
        rd_wen_i = wen; mem_read_i = ld; alu_sel_i = 4'd0; bsel_i = 0;
    endtask

    // Value an instruction in ID should see for source register a.
    function automatic logic [31:0] operand(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (m_valid && m_wen && !m_mr && m_rd == a) return ex_result_i;
        if (mem_fwd_wen_i && mem_fwd_addr_i == a) return mem_fwd_data_i;
        if (wb_wen_i && wb_addr_i == a) return wb_data_i;
        return m_rf[a];
    endfunction

    // One clock: check stall before the edge, the pipeline register after it.
    task automatic step();
        logic [31:0] e_rs1, e_rs2;
        logic        e_stall, latched;
        #3;
        e_rs1   = operand(rs1_addr_i);
        e_rs2   = operand(rs2_addr_i);
        e_stall = valid_i && !flush_i && m_valid && m_mr && m_rd != 0
                  && (m_rd == rs1_addr_i || m_rd == rs2_addr_i);
        chk("stall", {31'b0, stall_o}, {31'b0, e_stall});
        @(posedge clk_i);
        #1;
        if (wb_wen_i && wb_addr_i != 0) m_rf[wb_addr_i] = wb_data_i;
        latched = !(flush_i || e_stall);
        if (!latched) begin
            m_valid = 0; m_wen = 0; m_mr = 0;
        end else begin
            m_valid = valid_i;
            m_rs1   = e_rs1;
            m_opb   = bsel_i ? imm_i : e_rs2;
            m_sd    = e_rs2;
            m_alu   = alu_sel_i;
            m_rd    = rd_addr_i;
            m_wen   = valid_i && rd_wen_i;
            m_mr    = valid_i && mem_read_i;
        end
        chk("ex_valid", {31'b0, ex_valid_o}, {31'b0, m_valid});
        chk("ex_rd_wen", {31'b0, ex_rd_wen_o}, {31'b0, m_wen});
        chk("ex_mem_read", {31'b0, ex_mem_read_o}, {31'b0, m_mr});
        if (latched) begin
            chk("ex_rs1", ex_rs1_o, m_rs1);
            chk("ex_opb", ex_opb_o, m_opb);
            chk("ex_store_data", ex_store_data_o, m_sd);
            chk("ex_alu_sel", {28'b0, ex_alu_sel_o}, {28'b0, m_alu});
            chk("ex_rd_addr", {27'b0, ex_rd_addr_o}, {27'b0, m_rd});
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_i = 1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 0;
        step();

        // 1: load into x5 while WB writes x5 = 7, then reset in the middle of the stall.
        issue(5'd1, 5'd2, 5'd5, 1, 1);
        wb_wen_i = 1; wb_addr_i = 5'd5; wb_data_i = 32'd7;
        step();
        idle_inputs();
        issue(5'd5, 5'd0, 5'd9, 1, 0);
        #2;
        chk("pre_reset_stall", {31'b0, stall_o}, 32'd1);
        rst_i = 1;
        #1;
        model_reset();
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_ex_valid", {31'b0, ex_valid_o}, 32'd0);
        chk("rst_ex_rs1", ex_rs1_o, 32'd0);
        chk("rst_ex_opb", ex_opb_o, 32'd0);
        chk("rst_ex_store_data", ex_store_data_o, 32'd0);
        chk("rst_ex_alu_sel", {28'b0, ex_alu_sel_o}, 32'd0);
        chk("rst_ex_rd_addr", {27'b0, ex_rd_addr_o}, 32'd0);
        chk("rst_ex_rd_wen", {31'b0, ex_rd_wen_o}, 32'd0);
        chk("rst_ex_mem_read", {31'b0, ex_mem_read_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 0;
        issue(5'd5, 5'd0, 5'd0, 0, 0);
        step();
        chk("x5_after_reset", ex_rs1_o, 32'd0);

        // 2: write-through bypass.
        idle_inputs();
        issue(5'd3, 5'd0, 5'd0, 0, 0);
        wb_wen_i = 1; wb_addr_i = 5'd3; wb_data_i = 32'hDEAD_BEEF;
        step();
        chk("wb_bypass", ex_rs1_o, 32'hDEAD_BEEF);

        // 3: EX beats MEM beats WB; then MEM beats WB.
        idle_inputs();
        issue(5'd0, 5'd0, 5'd4, 1, 0);
        step();
        issue(5'd0, 5'd4, 5'd0, 0, 0);
        ex_result_i = 32'd5;
        mem_fwd_wen_i = 1; mem_fwd_addr_i = 5'd4; mem_fwd_data_i = 32'd9;
        wb_wen_i = 1; wb_addr_i = 5'd4; wb_data_i = 32'd11;
        step();
        chk("prio_ex", ex_opb_o, 32'd5);
        step();
        chk("prio_mem", ex_opb_o, 32'd9);

        // 4: load-use stall, bubble, then re-issue picks up MEM data.
        idle_inputs();
        issue(5'd0, 5'd0, 5'd6, 1, 1);
        step();
        issue(5'd6, 5'd0, 5'd8, 1, 0);
        #2;
        chk("load_use_stall", {31'b0, stall_o}, 32'd1);
        step();
        chk("load_use_bubble", {31'b0, ex_valid_o}, 32'd0);
        mem_fwd_wen_i = 1; mem_fwd_addr_i = 5'd6; mem_fwd_data_i = 32'h40;
        step();
        chk("load_use_reissue", ex_rs1_o, 32'h40);

        // 5: flush beats stall.
        idle_inputs();
        issue(5'd0, 5'd0, 5'd7, 1, 1);
        step();
        issue(5'd7, 5'd0, 5'd10, 1, 0);
        flush_i = 1;
        #2;
        chk("flush_no_stall", {31'b0, stall_o}, 32'd0);
        step();
        chk("flush_valid", {31'b0, ex_valid_o}, 32'd0);
        chk("flush_rd_wen", {31'b0, ex_rd_wen_o}, 32'd0);

        // 6: x0 is never forwarded; immediate operand B.
        idle_inputs();
        issue(5'd0, 5'd0, 5'd0, 1, 0);
        step();
        issue(5'd0, 5'd0, 5'd0, 0, 0);
        ex_result_i = 32'h55;
        wb_wen_i = 1; wb_addr_i = 5'd0; wb_data_i = 32'h1234;
        bsel_i = 1; imm_i = 32'hFFFF_FFFC;
        step();
        chk("x0_rs1", ex_rs1_o, 32'd0);
        chk("imm_opb", ex_opb_o, 32'hFFFF_FFFC);

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            valid_i        = ($urandom_range(0, 3) != 0);
            rs1_addr_i     = 5'($urandom_range(0, 7));
            rs2_addr_i     = 5'($urandom_range(0, 7));
            rd_addr_i      = 5'($urandom_range(0, 7));
            rd_wen_i       = 1'($urandom_range(0, 1));
            mem_read_i     = ($urandom_range(0, 2) == 0);
            alu_sel_i      = 4'($urandom_range(0, 10));
            bsel_i         = 1'($urandom_range(0, 1));
            imm_i          = $urandom;
            flush_i        = ($urandom_range(0, 9) == 0);
            ex_result_i    = $urandom;
            mem_fwd_wen_i  = 1'($urandom_range(0, 1));
            mem_fwd_addr_i = 5'($urandom_range(0, 7));
            mem_fwd_data_i = $urandom;
            wb_wen_i       = 1'($urandom_range(0, 1));
            wb_addr_i      = 5'($urandom_range(0, 7));
            wb_data_i      = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
